// File: rtl/ifu_snap_fifo.sv
// ifu_snap_fifo: small synchronous FIFO holding IFU state snapshots.
// Registered head output (no flow-through from snap_data), sticky overflow
// flag, synchronous flush and an asynchronous active-low reset of the
// control state only. Payload storage is never cleared.
// Optional build macro: E203_IFU_SNAP_PARITY_EN adds one even-parity bit per
// entry, with snap_perr_inj as an error-injection hook. The port list is the
// same in both builds.
module ifu_snap_fifo #(
    parameter  int DW = 104,
    parameter  int DP = 4,
    localparam int AW = (DP > 1) ? $clog2(DP) : 1,
    localparam int CW = $clog2(DP) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          snap_valid,
    output logic          snap_ready,
    input  logic [DW-1:0] snap_data,
    input  logic          snap_perr_inj,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_perr,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          ovf_err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DP);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] mem_q [DP];

    logic push;
    logic pop;
    logic wr_en;

    // Handshakes come straight off the occupancy register; a full FIFO never
    // accepts even if the head is being popped in the same cycle.
    assign snap_ready = (cnt_q != FULL_CNT);
    assign out_valid  = (cnt_q != '0);
    assign push       = snap_valid & snap_ready;
    assign pop        = out_valid & out_ready;
    // Flush wins over a same-cycle push, so the entry is not written either.
    assign wr_en      = push & ~flush;

    assign count    = cnt_q;
    assign ovf_err  = ovf_q;
    assign out_data = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            // DP is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (snap_valid && !snap_ready) ovf_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage: written on accepted push only, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= snap_data;
    end

`ifdef E203_IFU_SNAP_PARITY_EN
    logic [DP-1:0] par_q;

    // Even parity over the payload; the inject hook flips the stored bit.
    always_ff @(posedge clk) begin
        if (wr_en) par_q[wr_ptr_q] <= (^snap_data) ^ snap_perr_inj;
    end

    assign out_perr = out_valid & (par_q[rd_ptr_q] != (^out_data));
`else
    logic unused_perr_inj;

    assign unused_perr_inj = snap_perr_inj;
    assign out_perr        = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_snap_fifo.sv
// Directed, table-driven bench for ifu_snap_fifo (DP=4, DW=104), plus a
// hand-written asynchronous mid-operation reset sequence.
module tb_ifu_snap_fifo;

    localparam int DW = 104;
    localparam int DP = 4;
    localparam int CW = 3;
`ifdef E203_IFU_SNAP_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          snap_valid;
    logic          snap_ready;
    logic [DW-1:0] snap_data;
    logic          snap_perr_inj;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_perr;
    logic          flush;
    logic [CW-1:0] count;
    logic          ovf_err;

    int errs   = 0;
    int checks = 0;

    ifu_snap_fifo #(.DW(DW), .DP(DP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snap_valid   (snap_valid),
        .snap_ready   (snap_ready),
        .snap_data    (snap_data),
        .snap_perr_inj(snap_perr_inj),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_perr     (out_perr),
        .flush        (flush),
        .count        (count),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] d;
        logic       inj;
        logic       ordy;
        logic       fl;
        logic [2:0] cnt;
        logic       srdy;
        logic       oval;
        logic [7:0] od;
        logic       ovf;
        logic       perr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic sv, input logic [7:0] d, input logic inj,
                       input logic ordy, input logic fl, input logic [2:0] cnt,
                       input logic [7:0] od, input logic ovf, input logic perr);
        vec_t v;
        v.sv = sv; v.d = d; v.inj = inj; v.ordy = ordy; v.fl = fl;
        v.cnt = cnt; v.srdy = (cnt != 3'd4); v.oval = (cnt != 3'd0);
        v.od = od; v.ovf = ovf; v.perr = perr;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        snap_valid = v.sv; snap_data = DW'(v.d); snap_perr_inj = v.inj;
        out_ready = v.ordy; flush = v.fl;
        @(posedge clk);
        #1;
        chk({tag, " count"},      count,      v.cnt);
        chk({tag, " snap_ready"}, snap_ready, v.srdy);
        chk({tag, " out_valid"},  out_valid,  v.oval);
        chk({tag, " ovf_err"},    ovf_err,    v.ovf);
        chk({tag, " out_perr"},   out_perr,   v.perr);
        if (v.oval) chk({tag, " out_data"}, out_data, {96'd0, v.od});
    endtask

    initial begin
        vec_t one;
        // fill, then drain in order; extra pop while empty is ignored
        add(1, 8'h01, 0, 0, 0, 1, 8'h01, 0, 0);
        add(1, 8'h02, 0, 0, 0, 2, 8'h01, 0, 0);
        add(1, 8'h03, 0, 0, 0, 3, 8'h01, 0, 0);
        add(1, 8'h04, 0, 0, 0, 4, 8'h01, 0, 0);
        add(0, 8'h00, 0, 1, 0, 3, 8'h02, 0, 0);
        add(0, 8'h00, 0, 1, 0, 2, 8'h03, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h04, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        // overflow: push while full, flag sticks, contents intact, flush clears
        add(1, 8'h05, 0, 0, 0, 1, 8'h05, 0, 0);
        add(1, 8'h06, 0, 0, 0, 2, 8'h05, 0, 0);
        add(1, 8'h07, 0, 0, 0, 3, 8'h05, 0, 0);
        add(1, 8'h08, 0, 0, 0, 4, 8'h05, 0, 0);
        add(1, 8'h09, 0, 0, 0, 4, 8'h05, 1, 0);
        add(0, 8'h00, 0, 0, 0, 4, 8'h05, 1, 0);
        add(0, 8'h00, 0, 1, 0, 3, 8'h06, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
        // push while full but flushing does not raise overflow
        add(1, 8'h30, 0, 0, 0, 1, 8'h30, 0, 0);
        add(1, 8'h31, 0, 0, 0, 2, 8'h30, 0, 0);
        add(1, 8'h32, 0, 0, 0, 3, 8'h30, 0, 0);
        add(1, 8'h33, 0, 0, 0, 4, 8'h30, 0, 0);
        add(1, 8'h34, 0, 0, 1, 0, 8'h00, 0, 0);
        // simultaneous push+pop at count 2 across several pointer wraps
        add(1, 8'h10, 0, 0, 0, 1, 8'h10, 0, 0);
        add(1, 8'h11, 0, 0, 0, 2, 8'h10, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(1, 8'(8'h11 + k), 0, 1, 0, 2, 8'(8'h10 + k), 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 8'h1B, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        // flush beats a same-cycle push and pop
        add(1, 8'h20, 0, 0, 0, 1, 8'h20, 0, 0);
        add(1, 8'h21, 0, 0, 0, 2, 8'h20, 0, 0);
        add(1, 8'h22, 0, 0, 0, 3, 8'h20, 0, 0);
        add(1, 8'h23, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'h24, 0, 0, 0, 1, 8'h24, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        // parity injection on 0xA5 is visible only while it is the head
        add(1, 8'hA5, 1, 0, 0, 1, 8'hA5, 0, PAR);
        add(1, 8'h03, 0, 0, 0, 2, 8'hA5, 0, PAR);
        add(0, 8'h00, 0, 1, 0, 1, 8'h03, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 8'h5A, 0, 0, 0, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);

        rst_n = 1'b0; snap_valid = 0; snap_data = '0; snap_perr_inj = 0;
        out_ready = 0; flush = 0;
        #1;
        chk("reset count",      count,      0);
        chk("reset snap_ready", snap_ready, 1);
        chk("reset out_valid",  out_valid,  0);
        chk("reset out_perr",   out_perr,   0);
        chk("reset ovf_err",    ovf_err,    0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("v%0d", i));

        // asynchronous reset between edges with three entries queued
        for (int i = 0; i < 3; i++) begin
            one = '{sv:1, d:8'(8'h40 + i), inj:0, ordy:0, fl:0, cnt:3'(i + 1),
                    srdy:1, oval:1, od:8'h40, ovf:0, perr:0};
            apply(one, $sformatf("pre_rst%0d", i));
        end
        @(negedge clk);
        snap_valid = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst count",      count,      0);
        chk("midrst out_valid",  out_valid,  0);
        chk("midrst snap_ready", snap_ready, 1);
        chk("midrst out_perr",   out_perr,   0);
        #1 rst_n = 1'b1;
        one = '{sv:1, d:8'h50, inj:0, ordy:0, fl:0, cnt:3'd1,
                srdy:1, oval:1, od:8'h50, ovf:0, perr:0};
        apply(one, "post_rst push");
        one = '{sv:0, d:8'h00, inj:0, ordy:1, fl:0, cnt:3'd0,
                srdy:1, oval:0, od:8'h00, ovf:0, perr:0};
        apply(one, "post_rst pop");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
